// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and defaults
// Mode encoding and default widths shared by the baud generator and the Tx/Rx FSMs.
package uart_pkg;

   typedef enum logic {
      MODE_BIT = 1'b0,
      MODE_OVS = 1'b1
   } uart_mode_e;

   localparam int DEF_CNT_W  = 32;
   localparam int DEF_FRAC_W = 4;
   localparam int DEF_OVS    = 16;

endpackage

// File: rtl/uart_baud_gen_if.sv
// rtl/uart_baud_gen_if.sv - control and strobe bundle of the baud generator
// The master (software/FSM side) drives the rate controls; the slave returns the strobes.
interface uart_baud_gen_if #(
   parameter int CNT_W  = 32,
   parameter int FRAC_W = 4,
   parameter int OVS    = 16
);
   localparam int OS_W = $clog2(OVS);

   logic              enable;
   logic              resync;
   logic              mode;
   logic [CNT_W-1:0]  divisor;
   logic [FRAC_W-1:0] frac;
   logic              tick;
   logic              end_bit_time;
   logic              mid_bit;
   logic [OS_W-1:0]   os_count;

   modport master (
      output enable, resync, mode, divisor, frac,
      input  tick, end_bit_time, mid_bit, os_count
   );

   modport slave (
      input  enable, resync, mode, divisor, frac,
      output tick, end_bit_time, mid_bit, os_count
   );
endinterface

// File: rtl/frac_period_counter.sv
// rtl/frac_period_counter.sv - fractional-N base tick generator
// Period is divisor+1 cycles, stretched by one whenever the phase accumulator carries.
module frac_period_counter #(
   parameter int CNT_W  = 32,
   parameter int FRAC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              enable,
   input  logic [CNT_W-1:0]  divisor,
   input  logic [FRAC_W-1:0] frac,
   output logic              tick
);
   logic [CNT_W-1:0]  r_q;
   logic [FRAC_W-1:0] r_acc;
   logic              r_ext;

   logic [CNT_W:0]    w_term;
   logic              w_hit;
   logic [FRAC_W:0]   w_acc_sum;

   // One extra bit keeps divisor=all-ones plus a stretch from wrapping to zero.
   assign w_term    = {1'b0, divisor} + {{CNT_W{1'b0}}, r_ext};
   assign w_hit     = ({1'b0, r_q} >= w_term);
   assign w_acc_sum = {1'b0, r_acc} + {1'b0, frac};
   assign tick      = enable & w_hit & ~rst & ~clr;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_q   <= '0;
         r_acc <= '0;
         r_ext <= 1'b0;
      end else if (enable) begin
         if (w_hit) begin
            r_q   <= '0;
            r_acc <= w_acc_sum[FRAC_W-1:0];
            r_ext <= w_acc_sum[FRAC_W];
         end else begin
            r_q   <= r_q + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - shared Tx/Rx baud generator
// Mode 0 emits bit ticks; mode 1 emits oversample ticks with mid-bit and end-of-bit strobes.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int OVS    = DEF_OVS
) (
   input  logic            clk,
   input  logic            rst,
   uart_baud_gen_if.slave  bg
);
   localparam int              OS_W    = $clog2(OVS);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVS - 1);
   localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVS / 2 - 1);

   logic            w_base_tick;
   logic            w_ovs;
   logic            w_os_last;
   logic            w_os_mid;
   logic [OS_W-1:0] r_os;

   frac_period_counter #(
      .CNT_W  (CNT_W),
      .FRAC_W (FRAC_W)
   ) u_period (
      .clk     (clk),
      .rst     (rst),
      .clr     (bg.resync),
      .enable  (bg.enable),
      .divisor (bg.divisor),
      .frac    (bg.frac),
      .tick    (w_base_tick)
   );

   assign w_ovs     = (bg.mode == MODE_OVS);
   assign w_os_last = (r_os == OS_LAST);
   assign w_os_mid  = (r_os == OS_MID);

   // The base tick is already suppressed by rst/resync/!enable, so it alone gates the index.
   always_ff @(posedge clk) begin
      if (rst || bg.resync) begin
         r_os <= '0;
      end else if (w_base_tick) begin
         if (!w_ovs || w_os_last) r_os <= '0;
         else                     r_os <= r_os + OS_W'(1);
      end
   end

   assign bg.tick         = w_base_tick;
   assign bg.end_bit_time = w_base_tick & (~w_ovs | w_os_last);
   assign bg.mid_bit      = w_base_tick & w_ovs & w_os_mid;
   assign bg.os_count     = w_ovs ? r_os : '0;
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - self-checking bench for uart_baud_gen
// Per-cycle scoreboard against a behavioural model plus directed timing checks.
module tb_uart_baud_gen;
   import uart_pkg::*;

   localparam int CNT_W  = 32;
   localparam int FRAC_W = 4;
   localparam int OVS    = 16;
   localparam int OS_W   = $clog2(OVS);

   typedef struct packed {
      logic            tick;
      logic            end_bit;
      logic            mid;
      logic [OS_W-1:0] os;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_baud_gen_if #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVS(OVS)) bus ();

   uart_baud_gen #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVS(OVS)) dut (
      .clk (clk),
      .rst (rst),
      .bg  (bus.slave)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   longint m_q;
   int     m_acc;
   bit     m_ext;
   int     m_os;

   int cyc, n_tick, n_end, n_mid, first_tick, first_mid, first_end, mid_idx;
   int tick_cyc[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic bit model_hit();
      return m_q >= (longint'(bus.divisor) + longint'(m_ext));
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      bit   t;
      t         = bus.enable && model_hit() && !rst && !bus.resync;
      e.tick    = t;
      e.end_bit = t && (bus.mode == MODE_BIT || m_os == OVS - 1);
      e.mid     = t && bus.mode == MODE_OVS && m_os == OVS / 2 - 1;
      e.os      = (bus.mode == MODE_OVS) ? OS_W'(m_os) : '0;
      return e;
   endfunction

   task automatic model_update();
      int s;
      if (rst || bus.resync) begin
         m_q = 0; m_acc = 0; m_ext = 0; m_os = 0;
      end else if (bus.enable) begin
         if (model_hit()) begin
            m_q   = 0;
            s     = m_acc + int'(bus.frac);
            m_ext = (s >= (1 << FRAC_W));
            m_acc = s % (1 << FRAC_W);
            if (bus.mode == MODE_OVS) m_os = (m_os == OVS - 1) ? 0 : m_os + 1;
         end else begin
            m_q = m_q + 1;
         end
      end
   endtask

   task automatic mark();
      cyc = 0; n_tick = 0; n_end = 0; n_mid = 0;
      first_tick = -1; first_mid = -1; first_end = -1; mid_idx = -1;
      tick_cyc.delete();
   endtask

   task automatic step();
      exp_t e, o;
      sb_q.push_back(model_out());
      @(negedge clk);
      o.tick    = bus.tick;
      o.end_bit = bus.end_bit_time;
      o.mid     = bus.mid_bit;
      o.os      = bus.os_count;
      e = sb_q.pop_front();
      check_eq("tick", o.tick, e.tick);
      check_eq("end_bit_time", o.end_bit, e.end_bit);
      check_eq("mid_bit", o.mid, e.mid);
      check_eq("os_count", o.os, e.os);
      cyc++;
      if (o.tick) begin
         n_tick++;
         tick_cyc.push_back(cyc);
         if (first_tick < 0) first_tick = cyc;
      end
      if (o.end_bit) begin
         n_end++;
         if (first_end < 0) first_end = cyc;
      end
      if (o.mid) begin
         n_mid++;
         if (first_mid < 0) begin first_mid = cyc; mid_idx = n_tick; end
      end
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic rs, input logic md,
                        input logic [CNT_W-1:0] dv, input logic [FRAC_W-1:0] fr);
      bus.enable = en; bus.resync = rs; bus.mode = md; bus.divisor = dv; bus.frac = fr;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_resync(input logic md, input logic [CNT_W-1:0] dv, input logic [FRAC_W-1:0] fr);
      drive(1'b0, 1'b1, md, dv, fr);
      step();
      drive(1'b1, 1'b0, md, dv, fr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n5;
      bit  found;
      m_q = 0; m_acc = 0; m_ext = 0; m_os = 0;
      rst = 1'b1;
      drive(1'b0, 1'b0, MODE_BIT, '0, '0);
      @(posedge clk); #1;
      mark();
      run(2);
      rst = 1'b0;
      run(10);
      check_eq("hold_ticks", n_tick, 0);

      // Integer divide, mode 0
      drive(1'b1, 1'b0, MODE_BIT, 32'd4, 4'd0);
      mark();
      run(25);
      check_eq("int_first_tick", first_tick, 5);
      check_eq("int_n_tick", n_tick, 5);
      check_eq("int_n_end", n_end, 5);
      check_eq("int_n_mid", n_mid, 0);

      // Fractional 3 + 8/16
      do_resync(MODE_BIT, 32'd3, 4'd8);
      mark();
      run(36);
      check_eq("frac8_n_tick", n_tick, 8);
      check_eq("frac8_last_tick", tick_cyc[7], 35);

      // Fractional 3 + 15/16
      do_resync(MODE_BIT, 32'd3, 4'd15);
      mark();
      run(84);
      check_eq("frac15_n_tick", n_tick, 17);
      check_eq("frac15_tick16", tick_cyc[16], 83);
      n5 = 0;
      for (int i = 2; i < 17; i++) if (tick_cyc[i] - tick_cyc[i-1] == 5) n5++;
      check_eq("frac15_long_periods", n5, 15);

      // Oversample, divisor 1
      do_resync(MODE_OVS, 32'd1, 4'd0);
      mark();
      run(40);
      check_eq("ovs_n_tick", n_tick, 20);
      check_eq("ovs_first_mid", first_mid, 16);
      check_eq("ovs_first_end", first_end, 32);
      check_eq("ovs_n_end", n_end, 1);

      // Resync while os=5 and Q mid-count
      do_resync(MODE_OVS, 32'd3, 4'd0);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (m_os == 5 && m_q == 2) found = 1;
         else step();
      end
      check_eq("resync_setup", found, 1);
      check_eq("resync_os_before", bus.os_count, 5);
      drive(1'b1, 1'b1, MODE_OVS, 32'd3, 4'd0);
      mark();
      step();
      check_eq("resync_no_strobe", n_tick + n_mid + n_end, 0);
      drive(1'b1, 1'b0, MODE_OVS, 32'd3, 4'd0);
      mark();
      run(40);
      check_eq("resync_first_mid", first_mid, 32);
      check_eq("resync_mid_tick_idx", mid_idx, 8);

      // Divisor lowered below Q
      do_resync(MODE_BIT, 32'd100, 4'd0);
      mark();
      run(50);
      check_eq("lower_pre_ticks", n_tick, 0);
      bus.divisor = 32'd3;
      mark();
      run(9);
      check_eq("lower_first_tick", first_tick, 1);
      check_eq("lower_second_tick", tick_cyc[1], 5);
      check_eq("lower_n_tick", n_tick, 3);

      // divisor=0: tick every cycle
      do_resync(MODE_BIT, 32'd0, 4'd0);
      mark();
      run(10);
      check_eq("div0_n_tick", n_tick, 10);
      check_eq("div0_first_tick", first_tick, 1);

      // enable low 7 cycles mid-period
      do_resync(MODE_BIT, 32'd9, 4'd0);
      mark();
      run(4);
      bus.enable = 1'b0;
      run(7);
      bus.enable = 1'b1;
      run(16);
      check_eq("gap_n_tick", n_tick, 2);
      check_eq("gap_first_tick", tick_cyc[0], 17);
      check_eq("gap_second_tick", tick_cyc[1], 27);

      check_eq("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Parametrised successor to the single-rate bit-time pulse counter; one instance serves both UART Tx and Rx.
- Generates a fractional-N base tick from the system clock.
- Mode 0: the base tick is the bit tick (Tx).
- Mode 1: the base tick is an OVS-times oversample tick, with a derived mid-bit sample strobe and end-of-bit strobe (Rx). Phase can be restarted by `resync` on a start-bit edge.

Parameters:
- CNT_W, 32, width of the integer divisor and period counter.
- FRAC_W, 4, width of the fractional divisor and phase accumulator.
- OVS, 16, oversample ratio in mode 1; even, at least 4.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  count enable; state holds when low.
- resync  in  1  synchronous phase restart (Rx start-bit detect).
- mode  in  1  0 = bit-rate tick, 1 = oversample.
- divisor  in  CNT_W  integer period minus one; base period is divisor+1 cycles.
- frac  in  FRAC_W  fractional extension, frac/2^FRAC_W cycles per base period.
- tick  out  1  base tick, one cycle wide.
- end_bit_time  out  1  end of bit period, one cycle wide.
- mid_bit  out  1  Rx sample strobe, one cycle wide; always 0 in mode 0.
- os_count  out  $clog2(OVS)  current oversample index; always 0 in mode 0.

Behaviour:
- State registers:
  - Q[CNT_W-1:0], the period counter.
  - acc[FRAC_W-1:0], the phase accumulator.
  - ext, a 1-bit flag meaning the current period is stretched by one cycle.
  - os[$clog2(OVS)-1:0], the oversample index.
- Priority per cycle: rst > resync > enable > hold.
- rst or resync: Q=0, acc=0, ext=0, os=0. The strobes are decoded from the post-reset state (all strobes 0 when enable is 0).
- Terminal value: term = divisor + ext, computed in CNT_W+1 bits so that divisor=all-ones with ext=1 does not overflow.
- Terminal condition: hit = (Q >= term). Using >= guarantees a terminal within one cycle if divisor is lowered below Q.
- tick = enable & hit & !rst & !resync. This is a combinational decode of registered state and inputs. Unlike the old block, it is gated by enable.
- On enable & hit:
  - Q = 0.
  - {carry, acc} = acc + frac.
  - ext = carry.
- On enable & !hit: Q = Q + 1.
- Resulting period: divisor+1 cycles, or divisor+2 when the previous wrap carried. The average period is divisor + 1 + frac/2^FRAC_W.
- divisor=0, frac=0: tick every enabled cycle.
- Mode 0:
  - end_bit_time = tick.
  - mid_bit = 0.
  - os stays 0.
- Mode 1:
  - On each tick, os = (os == OVS-1) ? 0 : os + 1.
  - end_bit_time = tick & (os == OVS-1).
  - mid_bit = tick & (os == OVS/2-1).
  - Therefore the first mid_bit after resync falls on the (OVS/2)-th tick and end_bit_time on the OVS-th.
- enable low: all state holds and all strobes are 0. Counting resumes from the held Q.
- Changing `mode` while enabled is allowed but not glitch-defined. Software changes mode only while enable is 0, then pulses resync.
- divisor and frac are sampled live every cycle. A change takes effect on the next compare or wrap.
- Reset values: tick=0, end_bit_time=0, mid_bit=0, os_count=0.

Decomposition:
- Shared package uart_pkg:
  - mode constants MODE_BIT=1'b0 and MODE_OVS=1'b1.
  - default OVS and FRAC_W localparams, shared with the Tx/Rx FSMs.
- Sub-module frac_period_counter (CNT_W, FRAC_W) owns Q, acc and ext.
  - Inputs: clk, rst, clr (= resync), enable, divisor, frac.
  - Output: tick.
- The top level adds the os counter and the strobe decode.

Test Plan:
- Reset and hold: rst=1 for 2 cycles, then enable=0 for 10 cycles -> all outputs 0; Q and os stay 0.
- Integer mode 0: divisor=4, frac=0, mode=0, enable=1 -> tick and end_bit_time every 5th cycle, first at cycle 5 after enable; mid_bit always 0.
- Fractional: divisor=3, frac=8 (FRAC_W=4) -> tick periods alternate 4,5,4,5 -> 8 ticks in 36 cycles; frac=15 -> 15 of every 16 periods are 5 cycles.
- Oversample: mode=1, OVS=16, divisor=1, then resync pulse -> ticks every 2 cycles; mid_bit on tick 8 (cycle 16 after resync); end_bit_time on tick 16 (cycle 32); os_count wraps 15->0.
- Resync mid-bit: mode=1, resync asserted when os=5 with Q mid-count -> no strobe that cycle; the next mid_bit comes exactly 8 ticks later.
- Boundary cases:
  - divisor lowered from 100 to 3 while Q=50 -> tick on the very next enabled cycle, then period 4.
  - divisor=0, frac=0 -> tick every cycle.
  - enable toggled low for 7 cycles mid-period -> period extended by exactly 7.
